// File: rtl/gpio_input_capture.sv
// GPIO input capture: two-flop synchronizer, optional per-pin debounce, sticky edge-event flags.
// Debounce counters are built only when GPIO_DEBOUNCE_EN is defined; otherwise levels pass straight through.
module gpio_input_capture #(
    parameter int N               = 9,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] pin,
    input  logic [N-1:0] mode,
    input  logic [N-1:0] rise_enable,
    input  logic [N-1:0] fall_enable,
    input  logic         clear_enable,
    input  logic [N-1:0] clear_mask,
    output logic [N-1:0] to_processor,
    output logic [N-1:0] event_flags,
    output logic         interrupt
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("gpio_input_capture: DEBOUNCE_CYCLES must be within 1..255");
    end

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] stable;
    logic [N-1:0] stable_prev;
    logic [N-1:0] set_bits;
    logic [N-1:0] clear_bits;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] count [N];

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < N; i++) begin
                count[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync2[i] == stable[i]) begin
                    count[i] <= 8'd0;
                end else if (count[i] == LAST_COUNT) begin
                    stable[i] <= sync2[i];
                    count[i]  <= 8'd0;
                end else begin
                    count[i] <= count[i] + 8'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
        end else begin
            stable <= sync2;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev <= '0;
        end else begin
            stable_prev <= stable;
        end
    end

    // Pins configured as outputs still read back, but never raise events.
    always_comb begin
        set_bits   = ((stable & ~stable_prev & rise_enable) |
                      (~stable & stable_prev & fall_enable)) & ~mode;
        clear_bits = clear_enable ? clear_mask : '0;
    end

    // Set wins over clear for the same bit in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            event_flags <= '0;
        end else begin
            event_flags <= (event_flags & ~clear_bits) | set_bits;
        end
    end

    assign to_processor = stable;
    assign interrupt    = |event_flags;

endmodule
